// File: rtl/ps2_key_receiver_pkg.sv
// Shared PS/2 definitions: protocol prefix bytes, receiver FSM states and
// the set-2 make codes used as piano note keys.
package ps2_key_receiver_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2State_t;

    localparam logic [7:0] DO   = 8'h1C;
    localparam logic [7:0] DOs  = 8'h1D;
    localparam logic [7:0] RE   = 8'h1B;
    localparam logic [7:0] REs  = 8'h24;
    localparam logic [7:0] MI   = 8'h23;
    localparam logic [7:0] FA   = 8'h2B;
    localparam logic [7:0] FAs  = 8'h2C;
    localparam logic [7:0] SOL  = 8'h34;
    localparam logic [7:0] SOLs = 8'h35;
    localparam logic [7:0] LA   = 8'h33;
    localparam logic [7:0] LAs  = 8'h3C;
    localparam logic [7:0] SI   = 8'h3B;

endpackage

// File: rtl/ps2_key_receiver_sync.sv
// Synchronises the PS/2 pins and debounces the device clock; emits a
// one-cycle sample pulse on each falling edge of the filtered clock.
module ps2_sync_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clk_kb,
    input  logic data_kb,
    output logic filtClk,
    output logic sampleEvent,
    output logic syncData
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    clkSync;
    logic [1:0]    dataSync;
    logic [CW-1:0] stableCnt;
    logic          filtPrev;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            clkSync   <= '1;
            dataSync  <= '1;
            stableCnt <= '0;
            filtClk   <= 1'b1;
            filtPrev  <= 1'b1;
        end else begin
            clkSync  <= {clkSync[0], clk_kb};
            dataSync <= {dataSync[0], data_kb};
            filtPrev <= filtClk;
            // Any sample matching the current level restarts the run count
            if (clkSync[1] == filtClk) begin
                stableCnt <= '0;
            end else if (stableCnt == CNT_LAST) begin
                filtClk   <= clkSync[1];
                stableCnt <= '0;
            end else begin
                stableCnt <= stableCnt + 1'b1;
            end
        end
    end

    always_comb begin
        sampleEvent = filtPrev & ~filtClk;
        syncData    = dataSync[1];
    end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: frame FSM with inter-bit timeout, and make/break
// tracking of the currently held key.
module ps2_key_receiver
    import ps2_key_receiver_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       clk_kb,
    input  logic       data_kb,
    output logic [7:0] oKeyCode,
    output logic [7:0] oCodeByte,
    output logic       oCodeValid,
    output logic       oFrameError
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic filtClk, sampleEvent, syncData;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) uSyncFilter (
        .Clock       (Clock),
        .Reset       (Reset),
        .clk_kb      (clk_kb),
        .data_kb     (data_kb),
        .filtClk     (filtClk),
        .sampleEvent (sampleEvent),
        .syncData    (syncData)
    );

    ps2State_t     state, stateNext;
    logic [2:0]    bitCnt, bitCntNext;
    logic [7:0]    shiftReg, shiftNext;
    logic          parityBit, parityNext;
    logic [TW-1:0] timer, timerNext;
    logic          frameOk, frameOkNext;
    logic          frameBad, frameBadNext;
    logic [7:0]    pendByte;
    logic          breakPending;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            bitCnt    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            timer     <= '0;
            frameOk   <= 1'b0;
            frameBad  <= 1'b0;
            pendByte  <= '0;
        end else begin
            state     <= stateNext;
            bitCnt    <= bitCntNext;
            shiftReg  <= shiftNext;
            parityBit <= parityNext;
            timer     <= timerNext;
            frameOk   <= frameOkNext;
            frameBad  <= frameBadNext;
            pendByte  <= shiftReg;
        end
    end

    always_comb begin
        stateNext    = state;
        bitCntNext   = bitCnt;
        shiftNext    = shiftReg;
        parityNext   = parityBit;
        timerNext    = sampleEvent ? '0 : timer + 1'b1;
        frameOkNext  = 1'b0;
        frameBadNext = 1'b0;
        unique case (state)
            IDLE: begin
                timerNext = '0;
                if (sampleEvent && !syncData) begin
                    stateNext  = DATA;
                    bitCntNext = '0;
                end
            end
            DATA: begin
                if (sampleEvent) begin
                    shiftNext  = {syncData, shiftReg[7:1]};
                    bitCntNext = bitCnt + 1'b1;
                    if (bitCnt == 3'd7) stateNext = PARITY;
                end
            end
            PARITY: begin
                if (sampleEvent) begin
                    parityNext = syncData;
                    stateNext  = STOP;
                end
            end
            STOP: begin
                if (sampleEvent) begin
                    stateNext = IDLE;
                    if (syncData && ^{parityBit, shiftReg}) frameOkNext  = 1'b1;
                    else                                   frameBadNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
        // Expiry only counts when no bit arrives in the same cycle
        if (state != IDLE && !sampleEvent && timer == TIMER_LAST) begin
            stateNext    = IDLE;
            timerNext    = '0;
            frameBadNext = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oKeyCode     <= '0;
            oCodeByte    <= '0;
            oCodeValid   <= 1'b0;
            oFrameError  <= 1'b0;
            breakPending <= 1'b0;
        end else begin
            oCodeValid  <= frameOk;
            oFrameError <= frameBad;
            if (frameOk) begin
                oCodeByte <= pendByte;
                if (pendByte == PS2_BREAK) begin
                    breakPending <= 1'b1;
                end else if (pendByte != PS2_EXT) begin
                    if (breakPending) begin
                        if (pendByte == oKeyCode) oKeyCode <= '0;
                        breakPending <= 1'b0;
                    end else begin
                        oKeyCode <= pendByte;
                    end
                end
            end
        end
    end

    assert property (@(posedge Clock) disable iff (Reset) !(oCodeValid && oFrameError));
    assert property (@(posedge Clock) disable iff (Reset) sampleEvent |-> !filtClk);

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: framed PS/2 bytes with hand-computed
// key tracking, latency, error, timeout, glitch and reset expectations.
module tb_ps2_key_receiver;

    localparam int unsigned TMO  = 1000;
    localparam int unsigned HALF = 30;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       clk_kb = 1'b1;
    logic       data_kb = 1'b1;
    logic [7:0] oKeyCode, oCodeByte;
    logic       oCodeValid, oFrameError;

    int vectors = 0;
    int miscompares = 0;
    int validCnt = 0;
    int errCnt = 0;
    int overlapCnt = 0;

    ps2_key_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .clk_kb      (clk_kb),
        .data_kb     (data_kb),
        .oKeyCode    (oKeyCode),
        .oCodeByte   (oCodeByte),
        .oCodeValid  (oCodeValid),
        .oFrameError (oFrameError)
    );

    always #10 Clock = ~Clock;

    always @(negedge Clock) begin
        if (oCodeValid) validCnt++;
        if (oFrameError) errCnt++;
        if (oCodeValid && oFrameError) overlapCnt++;
    end

    function automatic logic [10:0] frameBits(input logic [7:0] b, input logic flip, input logic stopBit);
        return {stopBit, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic kbBit(input logic b, input logic glitch);
        data_kb = b;
        tick(HALF);
        clk_kb = 1'b0;
        tick(HALF);
        clk_kb = 1'b1;
        if (glitch) begin
            tick(5);
            clk_kb = 1'b0;
            tick(3);
            clk_kb = 1'b1;
            tick(5);
        end
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic flip, input logic stopBit, input logic glitch);
        logic [10:0] f;
        f = frameBits(b, flip, stopBit);
        for (int i = 0; i < 11; i++) kbBit(f[i], glitch);
        data_kb = 1'b1;
        tick(40);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        tick(5);
        vectors++; if (oKeyCode !== 8'h00) begin miscompares++; $display("FAIL reset_key: got %h want 00", oKeyCode); end
        vectors++; if (oCodeByte !== 8'h00) begin miscompares++; $display("FAIL reset_byte: got %h want 00", oCodeByte); end
        vectors++; if (oCodeValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", oCodeValid); end
        vectors++; if (oFrameError !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", oFrameError); end
        Reset = 1'b0;
        tick(5);
    endtask

    task automatic test_single_latency;
        logic [10:0] f;
        int v0, e0, n;
        v0 = validCnt; e0 = errCnt;
        f = frameBits(8'h1C, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) kbBit(f[i], 1'b0);
        data_kb = 1'b1;
        tick(HALF);
        clk_kb = 1'b0;
        n = 0;
        while (n < 100) begin
            tick(1);
            n++;
            if (oCodeValid) break;
        end
        // 2 sync + 8 filter cycles, then FSM and output registers
        vectors++; if (n != 12) begin miscompares++; $display("FAIL latency: got %0d cycles want 12", n); end
        vectors++; if (oCodeByte !== 8'h1C) begin miscompares++; $display("FAIL single_byte: got %h want 1c", oCodeByte); end
        vectors++; if (oKeyCode !== 8'h1C) begin miscompares++; $display("FAIL single_key: got %h want 1c", oKeyCode); end
        clk_kb = 1'b1;
        tick(40);
        vectors++; if (validCnt - v0 != 1) begin miscompares++; $display("FAIL single_valid_cnt: got %0d want 1", validCnt - v0); end
        vectors++; if (errCnt - e0 != 0) begin miscompares++; $display("FAIL single_err_cnt: got %0d want 0", errCnt - e0); end
    endtask

    task automatic test_break;
        int v0;
        v0 = validCnt;
        sendFrame(8'h1C, 1'b0, 1'b1, 1'b0);
        sendFrame(8'hF0, 1'b0, 1'b1, 1'b0);
        vectors++; if (oKeyCode !== 8'h1C) begin miscompares++; $display("FAIL break_hold_key: got %h want 1c", oKeyCode); end
        vectors++; if (oCodeByte !== 8'hF0) begin miscompares++; $display("FAIL break_byte: got %h want f0", oCodeByte); end
        sendFrame(8'h1C, 1'b0, 1'b1, 1'b0);
        vectors++; if (oKeyCode !== 8'h00) begin miscompares++; $display("FAIL break_release_key: got %h want 00", oKeyCode); end
        vectors++; if (validCnt - v0 != 3) begin miscompares++; $display("FAIL break_valid_cnt: got %0d want 3", validCnt - v0); end
    endtask

    task automatic test_break_other;
        sendFrame(8'h1C, 1'b0, 1'b1, 1'b0);
        sendFrame(8'hF0, 1'b0, 1'b1, 1'b0);
        sendFrame(8'h1B, 1'b0, 1'b1, 1'b0);
        vectors++; if (oKeyCode !== 8'h1C) begin miscompares++; $display("FAIL break_other_key: got %h want 1c", oKeyCode); end
        vectors++; if (oCodeByte !== 8'h1B) begin miscompares++; $display("FAIL break_other_byte: got %h want 1b", oCodeByte); end
        sendFrame(8'h23, 1'b0, 1'b1, 1'b0);
        vectors++; if (oKeyCode !== 8'h23) begin miscompares++; $display("FAIL break_cleared_key: got %h want 23", oKeyCode); end
    endtask

    task automatic test_extended_typematic;
        int v0;
        v0 = validCnt;
        sendFrame(8'hF0, 1'b0, 1'b1, 1'b0);
        sendFrame(8'hE0, 1'b0, 1'b1, 1'b0);
        vectors++; if (oKeyCode !== 8'h23) begin miscompares++; $display("FAIL ext_key: got %h want 23", oKeyCode); end
        vectors++; if (oCodeByte !== 8'hE0) begin miscompares++; $display("FAIL ext_byte: got %h want e0", oCodeByte); end
        sendFrame(8'h23, 1'b0, 1'b1, 1'b0);
        vectors++; if (oKeyCode !== 8'h00) begin miscompares++; $display("FAIL ext_release_key: got %h want 00", oKeyCode); end
        sendFrame(8'h1C, 1'b0, 1'b1, 1'b0);
        sendFrame(8'h1C, 1'b0, 1'b1, 1'b0);
        vectors++; if (oKeyCode !== 8'h1C) begin miscompares++; $display("FAIL typematic_key: got %h want 1c", oKeyCode); end
        vectors++; if (validCnt - v0 != 5) begin miscompares++; $display("FAIL ext_valid_cnt: got %0d want 5", validCnt - v0); end
    endtask

    task automatic test_frame_error;
        int v0, e0;
        v0 = validCnt; e0 = errCnt;
        sendFrame(8'h1C, 1'b1, 1'b1, 1'b0);
        vectors++; if (errCnt - e0 != 1) begin miscompares++; $display("FAIL parity_err_cnt: got %0d want 1", errCnt - e0); end
        vectors++; if (validCnt - v0 != 0) begin miscompares++; $display("FAIL parity_valid_cnt: got %0d want 0", validCnt - v0); end
        vectors++; if (oKeyCode !== 8'h1C) begin miscompares++; $display("FAIL parity_key: got %h want 1c", oKeyCode); end
        sendFrame(8'h2B, 1'b0, 1'b0, 1'b0);
        vectors++; if (errCnt - e0 != 2) begin miscompares++; $display("FAIL stop_err_cnt: got %0d want 2", errCnt - e0); end
        vectors++; if (validCnt - v0 != 0) begin miscompares++; $display("FAIL stop_valid_cnt: got %0d want 0", validCnt - v0); end
        vectors++; if (oKeyCode !== 8'h1C) begin miscompares++; $display("FAIL stop_key: got %h want 1c", oKeyCode); end
        vectors++; if (oCodeByte !== 8'h1C) begin miscompares++; $display("FAIL stop_byte: got %h want 1c", oCodeByte); end
    endtask

    task automatic test_timeout;
        int v0, e0, firstErr;
        v0 = validCnt; e0 = errCnt;
        kbBit(1'b0, 1'b0);
        kbBit(1'b1, 1'b0);
        kbBit(1'b0, 1'b0);
        kbBit(1'b1, 1'b0);
        data_kb = 1'b1;
        tick(HALF);
        clk_kb = 1'b0;
        firstErr = 0;
        for (int n = 1; n <= int'(TMO) + 60; n++) begin
            tick(1);
            if (n == int'(HALF)) clk_kb = 1'b1;
            if (oFrameError && firstErr == 0) firstErr = n;
        end
        vectors++; if (firstErr != int'(TMO) + 12) begin miscompares++; $display("FAIL timeout_cycle: got %0d want %0d", firstErr, TMO + 12); end
        vectors++; if (errCnt - e0 != 1) begin miscompares++; $display("FAIL timeout_err_cnt: got %0d want 1", errCnt - e0); end
        sendFrame(8'h2B, 1'b0, 1'b1, 1'b0);
        vectors++; if (oKeyCode !== 8'h2B) begin miscompares++; $display("FAIL after_timeout_key: got %h want 2b", oKeyCode); end
        vectors++; if (validCnt - v0 != 1) begin miscompares++; $display("FAIL after_timeout_valid: got %0d want 1", validCnt - v0); end
    endtask

    task automatic test_glitch_reset;
        logic [10:0] f;
        int v0, e0;
        v0 = validCnt; e0 = errCnt;
        sendFrame(8'h23, 1'b0, 1'b1, 1'b1);
        vectors++; if (oKeyCode !== 8'h23) begin miscompares++; $display("FAIL glitch_key: got %h want 23", oKeyCode); end
        vectors++; if (validCnt - v0 != 1) begin miscompares++; $display("FAIL glitch_valid_cnt: got %0d want 1", validCnt - v0); end
        f = frameBits(8'h1B, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) kbBit(f[i], 1'b1);
        Reset = 1'b1;
        tick(4);
        vectors++; if (oKeyCode !== 8'h00) begin miscompares++; $display("FAIL midreset_key: got %h want 00", oKeyCode); end
        vectors++; if (oCodeByte !== 8'h00) begin miscompares++; $display("FAIL midreset_byte: got %h want 00", oCodeByte); end
        Reset = 1'b0;
        data_kb = 1'b1;
        tick(TMO + 50);
        vectors++; if (errCnt - e0 != 0) begin miscompares++; $display("FAIL midreset_err_cnt: got %0d want 0", errCnt - e0); end
        sendFrame(8'h1C, 1'b0, 1'b1, 1'b0);
        vectors++; if (oKeyCode !== 8'h1C) begin miscompares++; $display("FAIL post_reset_key: got %h want 1c", oKeyCode); end
        vectors++; if (oCodeByte !== 8'h1C) begin miscompares++; $display("FAIL post_reset_byte: got %h want 1c", oCodeByte); end
        vectors++; if (validCnt - v0 != 2) begin miscompares++; $display("FAIL post_reset_valid: got %0d want 2", validCnt - v0); end
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_break();
        test_break_other();
        test_extended_typematic();
        test_frame_error();
        test_timeout();
        test_glitch_reset();
        vectors++; if (overlapCnt != 0) begin miscompares++; $display("FAIL valid_err_overlap: got %0d want 0", overlapCnt); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive equal Clock samples required before the filtered clk_kb level changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: idle Clock cycles allowed between sample events inside a frame (1 ms at 50 MHz).
REQ-003 Clock  input  1  system clock; all logic is clocked on its rising edge.
REQ-004 Reset  input  1  reset; synchronous, active-high.
REQ-005 clk_kb  input  1  PS/2 device clock; asynchronous to Clock.
REQ-006 data_kb  input  1  PS/2 device data; asynchronous to Clock.
REQ-007 oKeyCode  output  8  make code of the currently held key; 8'h00 when no key is held; feeds the piano display stage.
REQ-008 oCodeByte  output  8  last accepted raw byte.
REQ-009 oCodeValid  output  1  one-cycle pulse per accepted byte.
REQ-010 oFrameError  output  1  one-cycle pulse per rejected or aborted frame.

Function
REQ-011 clk_kb and data_kb SHALL each pass through a 2-flop synchronizer; no other logic SHALL use the raw pins.
REQ-012 The filtered clock SHALL change level only after the synchronized clk_kb has held the new level for FILTER_LEN consecutive cycles.
REQ-013 A sample event SHALL be a one-cycle pulse on each 1->0 transition of the filtered clock; data is the synchronized data_kb in that cycle.
REQ-014 FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: a sample event with data=0 SHALL go to DATA with bit count 0; a sample event with data=1 SHALL stay in IDLE with no error.
REQ-016 DATA: each sample event SHALL shift data in LSB first; after the 8th bit the FSM SHALL go to PARITY.
REQ-017 PARITY: a sample event SHALL store the parity bit and go to STOP.
REQ-018 STOP: a sample event SHALL accept the byte when stop=1 and the 9 data+parity bits hold an odd number of ones; otherwise it SHALL pulse oFrameError. Either way the FSM SHALL return to IDLE.
REQ-019 Timing: oCodeValid, oCodeByte and oKeyCode SHALL update on the Clock edge ending the cycle after the STOP sample event (1-cycle latency).
REQ-020 Timeout: in DATA, PARITY or STOP, TIMEOUT_CYCLES cycles without a sample event SHALL discard the partial frame, pulse oFrameError and go to IDLE.
REQ-021 A sample event in the same cycle as timeout expiry SHALL win: the bit is taken and the counter is cleared.
REQ-022 An accepted byte of 8'hF0 SHALL set break_pending and leave oKeyCode unchanged.
REQ-023 An accepted byte of 8'hE0 SHALL be ignored for key tracking and SHALL NOT clear break_pending.
REQ-024 Other accepted byte with break_pending=1: oKeyCode SHALL become 8'h00 if the byte equals oKeyCode and is otherwise unchanged; break_pending SHALL clear.
REQ-025 Other accepted byte with break_pending=0: oKeyCode SHALL take the byte. A typematic repeat rewrites the same value.
REQ-026 oCodeValid SHALL pulse for every accepted byte, including F0 and E0; oCodeByte SHALL always take the accepted byte.
REQ-027 oCodeValid and oFrameError SHALL never be high in the same cycle.

Reset
REQ-028 While Reset is high: FSM to IDLE; shift register, bit count, timeout counter and break_pending cleared; filtered clock set to 1; oKeyCode=8'h00, oCodeByte=8'h00, oCodeValid=0, oFrameError=0.
REQ-029 Reset asserted mid-frame SHALL discard the frame without an oFrameError pulse; the first frame after reset is received normally.

Structure
REQ-030 Shared definitions file: PS2_BREAK=8'hF0, PS2_EXT=8'hE0, the FSM state encodings, and the existing note scan-code constants (DO, DOs, RE ... SI).
REQ-031 The synchronizer and glitch filter SHALL be one sub-module, ps2_sync_filter, which outputs the filtered clock, the sample pulse and the synchronized data.
REQ-032 The FSM, timeout and key tracking SHALL live in ps2_key_receiver.

Verification (FILTER_LEN=8, clk_kb period 80 us, Clock 50 MHz)
REQ-033 Frame 8'h1C (parity 0, stop 1) -> one oCodeValid pulse, oCodeByte=8'h1C, oKeyCode=8'h1C, no oFrameError.
REQ-034 Frames 1C, F0, 1C -> three oCodeValid pulses; oKeyCode goes 1C, stays 1C after F0, then 00 after the final 1C.
REQ-035 Frames 1C, F0, 1B -> oKeyCode stays 1C; the next frame 23 -> oKeyCode=23 (break_pending cleared).
REQ-036 Frame 8'h1C with parity bit 1 -> oFrameError pulse, no oCodeValid, oKeyCode unchanged; frame with stop=0 -> same result.
REQ-037 Send start + 4 data bits, then hold clk_kb high for 60000 cycles -> one oFrameError at cycle 50000 after the last sample, FSM in IDLE; the next good frame 8'h2B is accepted.
REQ-038 Inject 3-cycle low glitches on clk_kb between bits and assert Reset mid-frame -> glitches create no sample events; after reset, outputs are zero and the next frame 8'h1C is accepted.
